// File: rtl/sram_slot_arbiter.sv
// -----------------------------------------------------------------------------
// sram_slot_arbiter
//
// Shares one asynchronous SRAM between a read-only video fetch port and
// NPORTS CPU-side requesters. Reads take two cycles (RD1, RD2) and writes take
// three (WR1, WR2, WR3). The next winner is picked in IDLE, RD2 and WR3, so
// accesses run back-to-back with no dead cycle. All outputs are registered.
//
// Arbitration: video has priority. The exception is when VID_MAX video grants
// have been given in a row and a CPU port is waiting; the CPU port then wins.
// CPU ports are served round-robin, starting the search just above the last
// CPU port that was granted.
//
// Ports
//   clk, rst_n      single clock, asynchronous active-low reset
//   vid_req         video fetch request (held until vid_ack)
//   vid_addr        video fetch address
//   vid_ack         one-cycle grant pulse for video
//   vid_rdata       last video read data (held until the next video read)
//   vid_rvalid      one-cycle pulse, 2 cycles after vid_ack
//   port_req        per-port request (held until port_ack[i])
//   port_we         per-port write enable (1 = write)
//   port_addr       packed addresses, port i at [i*AW +: AW]
//   port_wdata      packed write data, port i at [i*DW +: DW]
//   port_ack        per-port one-cycle grant pulse
//   port_rdata      shared CPU read data (held until the next CPU read)
//   port_rvalid     per-port one-cycle pulse, 2 cycles after port_ack[i]
//   sram_a          SRAM address
//   sram_we_n       SRAM write strobe, active low
//   sram_oe_n       SRAM output enable, active low
//   sram_d          SRAM data bus, driven only during WR1..WR3
// -----------------------------------------------------------------------------
module sram_slot_arbiter #(
  parameter int AW      = 19,
  parameter int DW      = 8,
  parameter int NPORTS  = 2,
  parameter int VID_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 vid_req,
  input  logic [AW-1:0]        vid_addr,
  output logic                 vid_ack,
  output logic [DW-1:0]        vid_rdata,
  output logic                 vid_rvalid,

  input  logic [NPORTS-1:0]    port_req,
  input  logic [NPORTS-1:0]    port_we,
  input  logic [NPORTS*AW-1:0] port_addr,
  input  logic [NPORTS*DW-1:0] port_wdata,
  output logic [NPORTS-1:0]    port_ack,
  output logic [DW-1:0]        port_rdata,
  output logic [NPORTS-1:0]    port_rvalid,

  output logic [AW-1:0]        sram_a,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  inout  wire  [DW-1:0]        sram_d
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = (VID_MAX > 0) ? $clog2(VID_MAX + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR1,
    WR2,
    WR3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q,      state_d;
  logic [AW-1:0]       sram_a_q,     sram_a_d;
  logic                sram_we_n_q,  sram_we_n_d;
  logic                sram_oe_n_q,  sram_oe_n_d;
  logic                d_oe_q,       d_oe_d;
  logic [DW-1:0]       dout_q,       dout_d;
  logic                vid_ack_q,    vid_ack_d;
  logic                vid_rvalid_q, vid_rvalid_d;
  logic [DW-1:0]       vid_rdata_q,  vid_rdata_d;
  logic [NPORTS-1:0]   port_ack_q,   port_ack_d;
  logic [NPORTS-1:0]   port_rvalid_q, port_rvalid_d;
  logic [DW-1:0]       port_rdata_q, port_rdata_d;
  logic [PW-1:0]       rr_ptr_q,     rr_ptr_d;
  logic [CW-1:0]       vid_cnt_q,    vid_cnt_d;
  // Owner of the transfer in flight, used to route read data at RD2.
  logic                cur_vid_q,    cur_vid_d;
  logic [PW-1:0]       cur_port_q,   cur_port_d;

  // ---------------------------------------------------------------------------
  // Round-robin search over CPU ports, starting at rr_ptr+1 (mod NPORTS)
  // ---------------------------------------------------------------------------
  logic          cpu_any;
  logic [PW-1:0] cpu_idx;
  int            cand;

  // NOTE: every variable written in a combinational block gets a default at
  // the top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cpu_any = 1'b0;
    cpu_idx = rr_ptr_q;
    cand    = 0;
    for (int k = 1; k <= NPORTS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NPORTS) cand = cand - NPORTS;
      if (!cpu_any && port_req[cand]) begin
        cpu_any = 1'b1;
        cpu_idx = PW'(cand);
      end
    end
  end

  // Video loses only when it has used up its run of VID_MAX grants and a CPU
  // port is actually waiting; otherwise it keeps priority.
  logic vid_cnt_sat;
  logic vid_win;
  logic arb_point;

  assign vid_cnt_sat = (vid_cnt_q == CW'(VID_MAX));
  assign vid_win     = vid_req && !(cpu_any && vid_cnt_sat);
  assign arb_point   = (state_q == IDLE) || (state_q == RD2) || (state_q == WR3);

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    sram_a_d      = sram_a_q;
    sram_we_n_d   = sram_we_n_q;
    sram_oe_n_d   = sram_oe_n_q;
    d_oe_d        = d_oe_q;
    dout_d        = dout_q;
    vid_ack_d     = 1'b0;
    vid_rvalid_d  = 1'b0;
    vid_rdata_d   = vid_rdata_q;
    port_ack_d    = '0;
    port_rvalid_d = '0;
    port_rdata_d  = port_rdata_q;
    rr_ptr_d      = rr_ptr_q;
    vid_cnt_d     = vid_cnt_q;
    cur_vid_d     = cur_vid_q;
    cur_port_d    = cur_port_q;

    case (state_q)
      RD1: state_d = RD2;
      RD2: begin
        // The SRAM has had RD1 and RD2 to settle; sample the bus on the
        // edge that leaves RD2.
        if (cur_vid_q) begin
          vid_rdata_d  = sram_d;
          vid_rvalid_d = 1'b1;
        end else begin
          port_rdata_d              = sram_d;
          port_rvalid_d[cur_port_q] = 1'b1;
        end
      end
      WR1: begin
        state_d     = WR2;
        sram_we_n_d = 1'b0;
      end
      WR2: begin
        state_d     = WR3;
        sram_we_n_d = 1'b1;
      end
      default: ;
    endcase

    if (arb_point) begin
      // With no winner the bus is parked: strobes inactive, data released,
      // address left at its last value.
      state_d     = IDLE;
      sram_oe_n_d = 1'b1;
      sram_we_n_d = 1'b1;
      d_oe_d      = 1'b0;

      if (vid_win) begin
        state_d     = RD1;
        sram_a_d    = vid_addr;
        sram_oe_n_d = 1'b0;
        vid_ack_d   = 1'b1;
        cur_vid_d   = 1'b1;
        if (!vid_cnt_sat) vid_cnt_d = vid_cnt_q + 1'b1;
      end else if (cpu_any) begin
        port_ack_d[cpu_idx] = 1'b1;
        cur_vid_d           = 1'b0;
        cur_port_d          = cpu_idx;
        rr_ptr_d            = cpu_idx;
        vid_cnt_d           = '0;
        sram_a_d            = port_addr[int'(cpu_idx)*AW +: AW];
        if (port_we[cpu_idx]) begin
          state_d = WR1;
          dout_d  = port_wdata[int'(cpu_idx)*DW +: DW];
          d_oe_d  = 1'b1;
        end else begin
          state_d     = RD1;
          sram_oe_n_d = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  // The read-data registers are reset as well so the held outputs start
  // from a known zero rather than whatever the flops power up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sram_a_q      <= '0;
      sram_we_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
      d_oe_q        <= 1'b0;
      dout_q        <= '0;
      vid_ack_q     <= 1'b0;
      vid_rvalid_q  <= 1'b0;
      vid_rdata_q   <= '0;
      port_ack_q    <= '0;
      port_rvalid_q <= '0;
      port_rdata_q  <= '0;
      rr_ptr_q      <= PW'(NPORTS - 1);
      vid_cnt_q     <= '0;
      cur_vid_q     <= 1'b0;
      cur_port_q    <= '0;
    end else begin
      state_q       <= state_d;
      sram_a_q      <= sram_a_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_oe_n_q   <= sram_oe_n_d;
      d_oe_q        <= d_oe_d;
      dout_q        <= dout_d;
      vid_ack_q     <= vid_ack_d;
      vid_rvalid_q  <= vid_rvalid_d;
      vid_rdata_q   <= vid_rdata_d;
      port_ack_q    <= port_ack_d;
      port_rvalid_q <= port_rvalid_d;
      port_rdata_q  <= port_rdata_d;
      rr_ptr_q      <= rr_ptr_d;
      vid_cnt_q     <= vid_cnt_d;
      cur_vid_q     <= cur_vid_d;
      cur_port_q    <= cur_port_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sram_d      = d_oe_q ? dout_q : {DW{1'bz}};
  assign sram_a      = sram_a_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_oe_n   = sram_oe_n_q;
  assign vid_ack     = vid_ack_q;
  assign vid_rvalid  = vid_rvalid_q;
  assign vid_rdata   = vid_rdata_q;
  assign port_ack    = port_ack_q;
  assign port_rvalid = port_rvalid_q;
  assign port_rdata  = port_rdata_q;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_slot_arbiter
//
// Self-checking bench for sram_slot_arbiter with four CPU ports. A behavioural
// asynchronous SRAM drives the bus while sram_oe_n is low and stores on the
// rising edge of sram_we_n. Single accesses come from a table of hand-computed
// vectors; write timing, anti-starvation, reset during a write, round-robin
// order and request withdrawal are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_sram_slot_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int NP = 4;
  localparam int VM = 3;
  localparam int VID_CODE = 8;   // grant-log code for a video grant

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vid_req;
  logic [AW-1:0]    vid_addr;
  logic             vid_ack;
  logic [DW-1:0]    vid_rdata;
  logic             vid_rvalid;
  logic [NP-1:0]    port_req;
  logic [NP-1:0]    port_we;
  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_wdata;
  logic [NP-1:0]    port_ack;
  logic [DW-1:0]    port_rdata;
  logic [NP-1:0]    port_rvalid;
  logic [AW-1:0]    sram_a;
  logic             sram_we_n;
  logic             sram_oe_n;
  wire  [DW-1:0]    sram_d;

  sram_slot_arbiter #(
    .AW(AW), .DW(DW), .NPORTS(NP), .VID_MAX(VM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_ack(port_ack), .port_rdata(port_rdata),
    .port_rvalid(port_rvalid),
    .sram_a(sram_a), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_d(sram_d)
  );

  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            we_strobes = 0;

  assign sram_d = (!sram_oe_n && sram_we_n) ? mem[sram_a] : {DW{1'bz}};

  always @(negedge sram_we_n) we_strobes++;
  always @(posedge sram_we_n) if (rst_n) mem[sram_a] = sram_d;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    vid_req    = 1'b0;
    vid_addr   = '0;
    port_req   = '0;
    port_we    = '0;
    port_addr  = '0;
    port_wdata = '0;
  endtask

  task automatic set_port(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    port_we[p]             = we;
    port_addr[p*AW +: AW]  = a;
    port_wdata[p*DW +: DW] = d;
    port_req[p]            = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            is_vid;
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs [9];
  logic [DW-1:0] last_port_rd = '0;

  task automatic run_vec(input vec_t v, input int n);
    int got;
    got = 0;
    if (v.is_vid) begin
      vid_addr = v.addr;
      vid_req  = 1'b1;
    end else begin
      set_port(v.port, v.we, v.addr, v.wdata);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (v.is_vid ? vid_ack : port_ack[v.port]) begin
        got = i;
        break;
      end
    end
    vid_req  = 1'b0;
    port_req = '0;
    check($sformatf("vec%0d ack latency", n), got, 1);
    if (got == 0) return;
    check($sformatf("vec%0d sram_a at grant", n), sram_a, v.addr);
    if (!v.we) begin
      check($sformatf("vec%0d oe_n in RD1", n), sram_oe_n, 0);
      tick();
      check($sformatf("vec%0d rvalid early", n), v.is_vid ? vid_rvalid : port_rvalid[v.port], 0);
      tick();
      check($sformatf("vec%0d rvalid at ack+2", n), v.is_vid ? vid_rvalid : port_rvalid[v.port], 1);
      check($sformatf("vec%0d rdata", n), v.is_vid ? vid_rdata : port_rdata, v.exp);
      if (v.is_vid) check($sformatf("vec%0d port_rdata held", n), port_rdata, last_port_rd);
      else          last_port_rd = v.exp;
    end else begin
      tick();
      tick();
      tick();
      check($sformatf("vec%0d mem written", n), mem[v.addr], v.wdata);
    end
    check($sformatf("vec%0d idle strobes", n), {sram_oe_n, sram_we_n}, 2'b11);
    check($sformatf("vec%0d idle addr held", n), sram_a, v.addr);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int glog[$];
    int exp_as[6];
    int exp_rr[5];
    int got;
    int s0;
    int cnt_ack;
    int cnt_acc;
    int first_lat;

    exp_as = '{VID_CODE, VID_CODE, VID_CODE, 0, VID_CODE, VID_CODE};
    exp_rr = '{0, 1, 2, 3, 0};

    //              vid port we  addr       wdata  exp
    vecs[0] = '{1'b1, 0, 1'b0, 19'h00010, 8'h00, 8'h11};
    vecs[1] = '{1'b0, 0, 1'b0, 19'h00123, 8'h00, 8'h5A};
    vecs[2] = '{1'b1, 0, 1'b0, 19'h00000, 8'h00, 8'hE1};
    vecs[3] = '{1'b0, 2, 1'b1, 19'h00200, 8'h77, 8'h00};
    vecs[4] = '{1'b0, 3, 1'b0, 19'h00200, 8'h00, 8'h77};
    vecs[5] = '{1'b0, 1, 1'b0, 19'h7FFFF, 8'h00, 8'hC3};
    vecs[6] = '{1'b0, 3, 1'b1, 19'h00000, 8'h0F, 8'h00};
    vecs[7] = '{1'b1, 0, 1'b0, 19'h00000, 8'h00, 8'h0F};
    vecs[8] = '{1'b0, 0, 1'b0, 19'h40000, 8'h00, 8'h99};

    rst_n = 1'b0;
    clear_inputs();
    tick();
    mem[19'h00123] = 8'h5A;
    mem[19'h00010] = 8'h11;
    mem[19'h00000] = 8'hE1;
    mem[19'h40000] = 8'h99;
    mem[19'h7FFFF] = 8'h00;
    tick();
    tick();

    // Reset state
    check("reset sram_a", sram_a, 0);
    check("reset strobes", {sram_oe_n, sram_we_n}, 2'b11);
    check("reset acks", {vid_ack, port_ack}, 0);
    check("reset rvalids", {vid_rvalid, port_rvalid}, 0);
    check("reset rdata", {vid_rdata, port_rdata}, 0);

    rst_n = 1'b1;
    tick();

    // Write timing: port1 writes 0xC3 to 0x7FFFF
    s0 = we_strobes;
    set_port(1, 1'b1, 19'h7FFFF, 8'hC3);
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (port_ack[1]) begin got = i; break; end
    end
    port_req = '0;
    check("wr ack latency", got, 1);
    check("wr WR1 we_n", sram_we_n, 1);
    check("wr WR1 oe_n", sram_oe_n, 1);
    check("wr WR1 data", sram_d, 8'hC3);
    check("wr WR1 addr", sram_a, 19'h7FFFF);
    tick();
    check("wr WR2 we_n", sram_we_n, 0);
    check("wr WR2 data", sram_d, 8'hC3);
    tick();
    check("wr WR3 we_n", sram_we_n, 1);
    check("wr WR3 data", sram_d, 8'hC3);
    check("wr WR3 addr", sram_a, 19'h7FFFF);
    tick();
    check("wr idle we_n", sram_we_n, 1);
    check("wr single strobe", we_strobes - s0, 1);
    check("wr mem readback", mem[19'h7FFFF], 8'hC3);

    // Table of single accesses
    for (int n = 0; n < 9; n++) run_vec(vecs[n], n);

    // Anti-starvation: video held high, port0 waiting
    vid_addr = 19'h00010;
    vid_req  = 1'b1;
    set_port(0, 1'b0, 19'h00123, 8'h00);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (vid_ack) glog.push_back(VID_CODE);
      if (port_ack[0]) begin
        glog.push_back(0);
        port_req[0] = 1'b0;
      end
      if (glog.size() >= 6) break;
    end
    vid_req  = 1'b0;
    port_req = '0;
    check("starve grant count", glog.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < glog.size()) check($sformatf("starve grant%0d", i), glog[i], exp_as[i]);
    repeat (6) tick();

    // Reset asserted during WR2
    set_port(2, 1'b1, 19'h00333, 8'h3C);
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (port_ack[2]) begin got = i; break; end
    end
    port_req = '0;
    check("rst wr ack", got, 1);
    tick();
    check("rst WR2 we_n low", sram_we_n, 0);
    s0 = we_strobes;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst we_n released", sram_we_n, 1);
    check("rst bus released", sram_d !== 8'h3C, 1);
    check("rst sram_a cleared", sram_a, 0);
    check("rst rdata cleared", {vid_rdata, port_rdata}, 0);
    tick();
    tick();
    rst_n   = 1'b1;
    cnt_ack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({vid_ack, port_ack, vid_rvalid, port_rvalid} != 0) cnt_ack++;
    end
    check("rst no ack/rvalid after release", cnt_ack, 0);
    check("rst no further strobe", we_strobes - s0, 0);

    // Round-robin after reset: all ports requesting reads continuously
    glog.delete();
    first_lat = 0;
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(19'h00100 + p), 8'h00);
    for (int i = 1; i <= 30; i++) begin
      tick();
      for (int p = 0; p < NP; p++)
        if (port_ack[p]) begin
          glog.push_back(p);
          if (first_lat == 0) first_lat = i;
        end
      if (glog.size() >= 5) break;
    end
    port_req = '0;
    check("rr first grant latency", first_lat, 1);
    check("rr grant count", glog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) check($sformatf("rr grant%0d", i), glog[i], exp_rr[i]);
    repeat (6) tick();

    // Withdrawal: port0 pulses req for one cycle during a video read
    vid_addr = 19'h00010;
    vid_req  = 1'b1;
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (vid_ack) begin got = i; break; end
    end
    vid_req = 1'b0;
    check("wd video ack", got, 1);
    set_port(0, 1'b0, 19'h055AA, 8'h00);
    tick();
    port_req = '0;
    cnt_ack = 0;
    cnt_acc = 0;
    got     = 0;
    for (int i = 0; i < 8; i++) begin
      if (port_ack[0]) cnt_ack++;
      if (sram_a == 19'h055AA && (!sram_oe_n || !sram_we_n)) cnt_acc++;
      if (vid_rvalid) got++;
      tick();
    end
    check("wd no port0 ack", cnt_ack, 0);
    check("wd no port0 access", cnt_acc, 0);
    check("wd video rvalid once", got, 1);
    check("wd video rdata", vid_rdata, 8'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_slot_arbiter.md
SRAM_SLOT_ARBITER -- requirements
Module: sram_slot_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 19, SRAM address width.
REQ-002 The block SHALL have parameter DW, default 8, SRAM data width.
REQ-003 The block SHALL have parameter NPORTS, default 2, range 1..8, number of CPU-side requesters.
REQ-004 The block SHALL have parameter VID_MAX, default 3, max consecutive video grants while any CPU port is pending.
REQ-005 The block SHALL have ports: clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports: vid_req input 1, video fetch request; vid_addr input AW; vid_ack output 1; vid_rdata output DW; vid_rvalid output 1.
REQ-007 The block SHALL have ports: port_req input NPORTS; port_we input NPORTS; port_addr input NPORTS*AW, port i at [i*AW +: AW]; port_wdata input NPORTS*DW; port_ack output NPORTS; port_rdata output DW, shared; port_rvalid output NPORTS.
REQ-008 The block SHALL have ports: sram_a output AW; sram_we_n output 1; sram_oe_n output 1; sram_d inout DW.

Function
REQ-009 The FSM SHALL have states IDLE, RD1, RD2, WR1, WR2, WR3, and all outputs SHALL be registered.
REQ-010 Arbitration SHALL occur in IDLE, RD2 and WR3, giving back-to-back accesses with no dead cycle.
REQ-011 Video SHALL have priority over CPU ports, except when vid_cnt == VID_MAX and a CPU port is pending; then a CPU port SHALL win.
REQ-012 CPU ports SHALL be served round-robin, searching upward from rr_ptr+1 modulo NPORTS; rr_ptr SHALL be set to the granted index.
REQ-013 vid_cnt SHALL increment (saturating at VID_MAX) on each video grant and SHALL clear on each CPU grant.
REQ-014 On grant the block SHALL pulse the winner's ack for exactly one cycle and latch addr, we and wdata.
REQ-015 A requester SHALL hold req, addr, we and wdata stable until its ack; a req deasserted before ack is withdrawn with no access.
REQ-016 Read: RD1 SHALL drive sram_a with sram_oe_n=0; RD2 SHALL keep the address; at the RD2->next edge sram_d SHALL be captured into vid_rdata or port_rdata.
REQ-017 The matching vid_rvalid or port_rvalid[i] SHALL pulse for one cycle, 2 cycles after ack; read latency ack->rvalid is 2 cycles.
REQ-018 Write (CPU only; video is read-only): WR1 SHALL drive address and data with sram_we_n=1; WR2 SHALL drive sram_we_n=0; WR3 SHALL drive sram_we_n=1 with address and data held.
REQ-019 sram_d SHALL be driven only in WR1..WR3 and SHALL be high-Z otherwise; sram_oe_n SHALL be 1 in all write states.
REQ-020 port_rdata SHALL hold its value until the next CPU read completes; vid_rdata likewise.
REQ-021 With no requests, the FSM SHALL go to or stay in IDLE with sram_oe_n=1, sram_we_n=1, sram_a holding its last value.
REQ-022 A request arriving while a transfer is in progress SHALL wait for the next arbitration point; an active transfer SHALL never be aborted by a request.

Reset
REQ-023 rst_n low SHALL asynchronously force: state IDLE, sram_we_n=1, sram_oe_n=1, sram_d high-Z, sram_a=0, all ack and rvalid outputs 0, vid_rdata=0, port_rdata=0, rr_ptr=NPORTS-1, vid_cnt=0.
REQ-024 Reset asserted mid-write SHALL immediately release sram_we_n to 1, with no further write strobe after release.
REQ-025 After rst_n deasserts, the first arbitration SHALL occur at the first clk edge.

Verification
REQ-026 The bench SHALL cover single read: port0 reads addr 0x00123, SRAM model returns 0x5A -> port_ack[0] at cycle T, port_rvalid[0] at T+2, port_rdata=0x5A.
REQ-027 The bench SHALL cover write timing: port1 writes 0xC3 to 0x7FFFF -> sram_we_n low exactly one cycle (WR2), sram_d=0xC3 across WR1..WR3, model reads back 0xC3.
REQ-028 The bench SHALL cover anti-starvation: vid_req held high, port0 req high -> 3 video grants, then port0 granted, then video resumes.
REQ-029 The bench SHALL cover round-robin: NPORTS=4, all ports requesting continuously, video idle -> grant order 0,1,2,3,0.
REQ-030 The bench SHALL cover reset mid-write: rst_n low during WR2 -> sram_we_n=1 and sram_d high-Z in the same cycle, no ack or rvalid after release until a new request.
REQ-031 The bench SHALL cover withdrawal: port0 asserts req for one cycle while a video read is busy -> no port_ack[0] and no SRAM access for port0.
